grant_decoder: RTL

Registered 3-to-8 decoder: the consumer end of the 8-line priority-encoder path. Accepts 3-bit line indices over a valid/ready handshake and buffers them in a small FIFO. Replays each index as a one-hot `y` grant, held for a minimum number of cycles and then until the downstream line acknowledges it. It sits downstream of the encoder and returns the encoded request to its individual request line.

---
 rtl/grant_decoder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/grant_decoder.sv
// ----------------------------------------------------------------------------
// grant_decoder
//   Registered 3-to-8 decoder at the consumer end of the 8-line priority
//   encoder path. Line indices arrive over a valid/ready handshake, are
//   buffered in a DEPTH-entry FIFO and replayed one at a time as a one-hot
//   grant on y. A grant is held for at least MIN_HOLD cycles and then until
//   the downstream line acknowledges it.
//
//   Optional build macro: GRANT_DECODER_STATS_EN adds the grant_count output
//   (completed-grant counter, 8 bits, wraps). Without the macro the port and
//   the counter do not exist.
//
// Handshakes:
//   Input side : a transfer happens on a rising edge where in_valid and
//                in_ready are both high. in_valid may be raised at any time;
//                in_ready depends only on the level register, never on
//                in_valid.
//   Grant side : y/y_valid are registered. A grant completes on a rising edge
//                where y_valid is high, the grant has been up for MIN_HOLD
//                cycles (FSM in WAIT) and y_ack is high. y_ack at any other
//                time is ignored.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   synchronous active-low reset
//   enable      in   0 blocks launching new grants (FIFO still accepts)
//   in_valid    in   in_code valid
//   in_code     in   [2:0] line index 0..7
//   in_ready    out  FIFO level < DEPTH (combinational from level register)
//   y           out  [7:0] one-hot grant, 0 when no grant
//   y_valid     out  grant active
//   y_ack       in   grant release from the line
//   level       out  [clog2(DEPTH):0] FIFO occupancy
//   grant_count out  [7:0] completed grants (GRANT_DECODER_STATS_EN only)
//   fsm_state_o out  [1:0] FSM state for debug (0 IDLE, 1 HOLD, 2 WAIT)
// ----------------------------------------------------------------------------
module grant_decoder #(
   parameter int DEPTH    = 4,
   parameter int MIN_HOLD = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     in_valid,
   input  logic [2:0]               in_code,
   output logic                     in_ready,
   output logic [7:0]               y,
   output logic                     y_valid,
   input  logic                     y_ack,
   output logic [$clog2(DEPTH):0]   level,
`ifdef GRANT_DECODER_STATS_EN
   output logic [7:0]               grant_count,
`endif
   output logic [1:0]               fsm_state_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   // Wide enough to hold MIN_HOLD-1; at least one bit so the vector exists.
   localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // FIFO storage and pointers
   // ------------------------------------------------------------------------
   logic [2:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;

   // ------------------------------------------------------------------------
   // Grant FSM state and registered outputs
   // ------------------------------------------------------------------------
   state_t        state_q;
   logic [HW-1:0] hold_cnt_q;
   logic [7:0]    y_q;
   logic          y_valid_q;

   logic          push;
   logic          load;
   logic          grant_done;
   logic [2:0]    head;
   logic [7:0]    head_onehot;

   assign in_ready    = (level_q < LW'(DEPTH));
   assign push        = in_valid && in_ready;
   assign grant_done  = (state_q == S_WAIT) && y_ack;
   assign head        = mem_q[rd_ptr_q];
   assign head_onehot = 8'b0000_0001 << head;

   // A load is the only way an entry leaves the FIFO. From WAIT it chains
   // straight onto the acknowledged grant so there is no idle cycle.
   always_comb begin
      load = 1'b0;
      unique case (state_q)
         S_IDLE:  load = enable && (level_q != '0);
         S_WAIT:  load = y_ack && enable && (level_q != '0);
         default: load = 1'b0;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;   // wraps mod DEPTH (power of two)
      if (load) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, load})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem_q[wr_ptr_q] <= in_code;
      end
   end

   // ------------------------------------------------------------------------
   // Grant FSM. hold_cnt counts down the remaining HOLD cycles; the move to
   // WAIT is taken on the cycle it reads 1, so y_ack is first honoured on the
   // MIN_HOLD-th cycle of y_valid.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         hold_cnt_q <= '0;
         y_q        <= '0;
         y_valid_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (load) begin
                  y_q        <= head_onehot;
                  y_valid_q  <= 1'b1;
                  hold_cnt_q <= HW'(MIN_HOLD - 1);
                  state_q    <= (MIN_HOLD > 1) ? S_HOLD : S_WAIT;
               end
            end
            S_HOLD: begin
               hold_cnt_q <= hold_cnt_q - HW'(1);
               if (hold_cnt_q == HW'(1)) begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (grant_done) begin
                  if (load) begin
                     y_q        <= head_onehot;
                     y_valid_q  <= 1'b1;
                     hold_cnt_q <= HW'(MIN_HOLD - 1);
                     state_q    <= (MIN_HOLD > 1) ? S_HOLD : S_WAIT;
                  end else begin
                     y_q       <= '0;
                     y_valid_q <= 1'b0;
                     state_q   <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q    <= S_IDLE;
               hold_cnt_q <= '0;
               y_q        <= '0;
               y_valid_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef GRANT_DECODER_STATS_EN
   logic [7:0] grant_count_q;

   // Counts every acknowledged grant, including ones followed by a chained load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_count_q <= '0;
      end else if (grant_done) begin
         grant_count_q <= grant_count_q + 8'd1;
      end
   end

   assign grant_count = grant_count_q;
`endif

   assign y           = y_q;
   assign y_valid     = y_valid_q;
   assign level       = level_q;
   assign fsm_state_o = state_q;

endmodule
